poly_mod_add: RTL



---
 rtl/poly_mod_add.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/poly_mod_add.sv
// poly_mod_add
// ------------
// Streaming coefficient-wise modular adder for Kyber polynomials (q = 3329).
// A frame of N (a, b) pairs enters over a valid/ready input. Each pair
// produces c = (a + b) mod q over a valid/ready output, and the N-th result
// of the frame is tagged with out_last.
//
// Optional feature macro: POLY_MOD_SUB_EN
//   When defined, an op_sub input is added. A pair with op_sub=1 produces
//   (a - b) mod q instead of (a + b) mod q.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a frame (honoured only in IDLE)
//   in_valid   a/b pair valid
//   in_ready   block can accept a pair
//   a, b       coefficients, expected in [0, Q-1]
//   op_sub     per-pair subtract select (POLY_MOD_SUB_EN only)
//   out_valid  c valid
//   out_ready  downstream accepts c
//   c          result in [0, Q-1]
//   out_last   high with the N-th output of the frame
//   busy       high while a frame is running or draining
//   done       one-cycle pulse after the last output handshake

module poly_mod_add #(
   parameter int Q = 3329,
   parameter int N = 256,
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
`ifdef POLY_MOD_SUB_EN
   input  logic         op_sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] c,
   output logic         out_last,
   output logic         busy,
   output logic         done
);

   localparam int SW = W + 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
   localparam logic [SW-1:0] Q_S      = SW'(Q);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

   state_t        state_q;
   logic          busy_q;
   logic          done_q;
   logic [CW-1:0] in_cnt_q;
   logic [CW-1:0] out_cnt_q;

   logic          s1_valid_q;
   logic          s1_last_q;
   logic [SW-1:0] s1_val_q;
   logic [SW-1:0] s1_d;
`ifdef POLY_MOD_SUB_EN
   logic          s1_sub_q;
`endif

   logic          out_valid_q;
   logic          out_last_q;
   logic [W-1:0]  c_q;
   logic [W-1:0]  c_d;
   logic [SW-1:0] red_tmp;

   logic          en;
   logic          in_fire;
   logic          out_fire;

   // Both stages move together only when the output register is free or
   // being drained, so backpressure freezes the whole pipeline.
   assign en       = !out_valid_q || out_ready;
   assign in_ready = (state_q == RUN) && en;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign c         = c_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // Stage 1 arithmetic: 13-bit sum, or 13-bit two's-complement difference
   // when subtract mode is selected for this pair.
   always_comb begin
      s1_d = {1'b0, a} + {1'b0, b};
`ifdef POLY_MOD_SUB_EN
      if (op_sub) begin
         s1_d = {1'b0, a} - {1'b0, b};
      end
`endif
   end

   // Stage 2 reduction: a single conditional correction by Q. Out-of-range
   // inputs are not detected; they simply get the same single correction.
   always_comb begin
      red_tmp = (s1_val_q >= Q_S) ? (s1_val_q - Q_S) : s1_val_q;
`ifdef POLY_MOD_SUB_EN
      if (s1_sub_q) begin
         red_tmp = s1_val_q[SW-1] ? (s1_val_q + Q_S) : s1_val_q;
      end
`endif
      c_d = red_tmp[W-1:0];
   end

   // Frame control. busy and done are registered alongside the state so
   // they change on the same edge as the state they describe. The frame ends
   // when the output counter reaches the final index, which is the same
   // handshake that carries out_last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         if (in_fire) begin
            in_cnt_q <= in_cnt_q + CW'(1);
         end
         if (out_fire) begin
            out_cnt_q <= out_cnt_q + CW'(1);
         end
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q   <= RUN;
                  busy_q    <= 1'b1;
                  in_cnt_q  <= '0;
                  out_cnt_q <= '0;
               end
            end
            RUN: begin
               if (in_fire && (in_cnt_q == LAST_IDX)) begin
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (out_fire && (out_cnt_q == LAST_IDX)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Two-stage datapath. c only reloads when stage 1 holds real data so the
   // last result stays visible after out_valid falls; out_last follows
   // out_valid so it never lingers on an empty slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_val_q    <= '0;
`ifdef POLY_MOD_SUB_EN
         s1_sub_q    <= 1'b0;
`endif
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         c_q         <= '0;
      end else if (en) begin
         s1_valid_q <= in_fire;
         if (in_fire) begin
            s1_val_q  <= s1_d;
            s1_last_q <= (in_cnt_q == LAST_IDX);
`ifdef POLY_MOD_SUB_EN
            s1_sub_q  <= op_sub;
`endif
         end
         out_valid_q <= s1_valid_q;
         out_last_q  <= s1_valid_q && s1_last_q;
         if (s1_valid_q) begin
            c_q <= c_d;
         end
      end
   end

endmodule
